pwm_ramp_sequencer: RTL and testbench

//  Sequences the motor-drive PWM: start -> STAGE1 fixed duty -> STAGE2 fixed duty -> MANUAL (inc/dec).

---
 rtl/pwm_seq_pkg.sv | 17 +
 rtl/pwm_tick_gen.sv | 33 +++
 rtl/pwm_ramp_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwm_seq_pkg
// Shared definitions for the PWM ramp sequencer: duty width and the sequencer
// state encoding (also driven out on the o_state port).
// -----------------------------------------------------------------------------
package pwm_seq_pkg;

    localparam int unsigned DUTY_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STAGE1 = 2'b01,
        ST_STAGE2 = 2'b10,
        ST_MANUAL = 2'b11
    } seq_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// 16-bit prescaler producing a single-cycle tick every TICK_DIV clocks.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset (clears the prescaler)
//   o_tick  one-clock pulse, first one TICK_DIV-1 clocks after reset
// -----------------------------------------------------------------------------
module pwm_tick_gen #(
    parameter int unsigned TICK_DIV = 10000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_ramp_sequencer
// Motor-drive PWM sequencer: IDLE -> STAGE1 -> STAGE2 -> MANUAL (inc/dec),
// with stop abort from any state. Applied duty is shadowed and only changes
// at a period wrap, except that stop/reset force it to 0 immediately.
// Optional build macro SOFT_START_EN: at each wrap the duty moves by at most
// 1 toward its target instead of jumping.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_stop     level inputs; stop has priority
//   i_inc, i_dec        manual duty adjust (MANUAL only)
//   o_pwm_out           registered PWM output
//   o_pwm_light         copy of o_pwm_out for the indicator LED
//   o_duty              currently applied duty
//   o_state             00 IDLE, 01 STAGE1, 10 STAGE2, 11 MANUAL
// -----------------------------------------------------------------------------
module pwm_ramp_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 10000,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STAGE1_DUTY  = 10,
    parameter int unsigned STAGE2_DUTY  = 5,
    parameter int unsigned STAGE_TICKS  = 10000,
    parameter int unsigned REPEAT_TICKS = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic              o_pwm_out,
    output logic              o_pwm_light,
    output logic [DUTY_W-1:0] o_duty,
    output logic [1:0]        o_state
);

    localparam int unsigned SCNT_W = $clog2(STAGE_TICKS + 1);
    localparam int unsigned RCNT_W = $clog2(REPEAT_TICKS + 1);

    localparam logic [DUTY_W-1:0] P_LAST    = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] P_MAX     = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] S1_DUTY   = DUTY_W'(STAGE1_DUTY);
    localparam logic [DUTY_W-1:0] S2_DUTY   = DUTY_W'(STAGE2_DUTY);
    localparam logic [SCNT_W-1:0] STAGE_END = SCNT_W'(STAGE_TICKS);
    localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_TICKS - 1);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              w_run_entry;
    logic              w_tick;
    logic              w_wrap;
    logic              w_one_btn;
    logic [SCNT_W-1:0] r_scnt;
    logic [RCNT_W-1:0] r_rcnt;
    logic [DUTY_W-1:0] r_pcnt;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_mduty;
    logic [DUTY_W-1:0] w_target;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic              r_pwm;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    assign w_wrap    = w_tick && (r_pcnt == P_LAST);
    assign w_one_btn = i_inc ^ i_dec;

    // FSM next state; the stage counter is compared every clk, so a stage
    // ends on the clk after its last tick.
    always_comb begin
        w_state_nxt = r_state;
        w_run_entry = 1'b0;
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = ST_STAGE1;
                        w_run_entry = 1'b1;
                    end
                end
                ST_STAGE1: if (r_scnt == STAGE_END) w_state_nxt = ST_STAGE2;
                ST_STAGE2: if (r_scnt == STAGE_END) w_state_nxt = ST_MANUAL;
                ST_MANUAL: w_state_nxt = ST_MANUAL;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage counter only runs inside STAGE1/STAGE2 and restarts on any move.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == ST_IDLE)
                     || (r_state == ST_MANUAL)) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= r_scnt + SCNT_W'(1);
        end
    end

    // Period counter free-runs; starting a run realigns it to a fresh period.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_run_entry) begin
            r_pcnt <= '0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= r_pcnt + DUTY_W'(1);
        end
    end

    // Manual duty: one step per REPEAT_TICKS ticks of a single held button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rcnt  <= '0;
            r_mduty <= '0;
        end else if ((r_state != ST_MANUAL) || i_stop || !w_one_btn) begin
            r_rcnt <= '0;
        end else if (w_tick) begin
            if (r_rcnt == REP_LAST) begin
                r_rcnt <= '0;
                if (i_inc) begin
                    if (r_mduty < P_MAX) r_mduty <= r_mduty + DUTY_W'(1);
                end else begin
                    if (r_mduty != '0) r_mduty <= r_mduty - DUTY_W'(1);
                end
            end else begin
                r_rcnt <= r_rcnt + RCNT_W'(1);
            end
        end
    end

    always_comb begin
        w_target = '0;
        unique case (r_state)
            ST_IDLE:   w_target = '0;
            ST_STAGE1: w_target = S1_DUTY;
            ST_STAGE2: w_target = S2_DUTY;
            ST_MANUAL: w_target = r_mduty;
            default:   w_target = '0;
        endcase
    end

    always_comb begin
        w_duty_nxt = w_target;
`ifdef SOFT_START_EN
        if (w_target > r_duty) begin
            w_duty_nxt = r_duty + DUTY_W'(1);
        end else if (w_target < r_duty) begin
            w_duty_nxt = r_duty - DUTY_W'(1);
        end else begin
            w_duty_nxt = r_duty;
        end
`else
        w_duty_nxt = w_target;
`endif
    end

    // Duty shadow: updates only at a wrap so every period is complete.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop) begin
            r_duty <= '0;
        end else if (w_wrap) begin
            r_duty <= w_duty_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_duty > r_pcnt);
        end
    end

    assign o_pwm_out   = r_pwm;
    assign o_pwm_light = r_pwm;
    assign o_duty      = r_duty;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_sequencer
// Directed scenarios followed by random input traffic. A behavioural model
// (integer tick/period arithmetic) predicts state, duty and PWM every clock.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

    localparam int unsigned TDIV = 4;
    localparam int unsigned PER  = 10;
    localparam int unsigned S1   = 3;
    localparam int unsigned S2   = 2;
    localparam int unsigned STG  = 20;
    localparam int unsigned REP  = 3;
    localparam int SETTLE = 12 * PER * TDIV;

    logic       clk = 1'b0;
    logic       rst, start, stop, inc, dec;
    logic       pwm_out, pwm_light;
    logic [6:0] duty;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc   = 0;

    // Model state
    int m_cyc, m_ticks, m_origin, m_entry, m_held;
    int m_state, m_duty, m_md, m_pwm;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(
        .TICK_DIV     (TDIV),
        .PERIOD       (PER),
        .STAGE1_DUTY  (S1),
        .STAGE2_DUTY  (S2),
        .STAGE_TICKS  (STG),
        .REPEAT_TICKS (REP)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_inc       (inc),
        .i_dec       (dec),
        .o_pwm_out   (pwm_out),
        .o_pwm_light (pwm_light),
        .o_duty      (duty),
        .o_state     (state)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, n_cyc, got, exp);
        end
    endtask

    function automatic int target_of(input int st);
        case (st)
            0:       return 0;
            1:       return S1;
            2:       return S2;
            default: return m_md;
        endcase
    endfunction

    // One clock of the reference behaviour, using the inputs seen at this edge.
    task automatic model_step();
        bit tick, wrap;
        int pc, tgt, nxt_ticks;
        if (rst) begin
            m_cyc = 0; m_ticks = 0; m_origin = 0; m_entry = 0; m_held = 0;
            m_state = 0; m_duty = 0; m_md = 0; m_pwm = 0;
            return;
        end
        tick      = (m_cyc % TDIV) == TDIV - 1;
        pc        = (m_ticks - m_origin) % PER;
        wrap      = tick && (pc == PER - 1);
        nxt_ticks = m_ticks + (tick ? 1 : 0);
        tgt       = target_of(m_state);

        m_pwm = (!stop && (m_duty > pc)) ? 1 : 0;

        if (m_state == 3 && !stop && (inc != dec)) begin
            if (tick) begin
                m_held++;
                if (m_held % REP == 0) begin
                    if (inc) m_md = (m_md < PER) ? m_md + 1 : m_md;
                    else     m_md = (m_md > 0) ? m_md - 1 : 0;
                end
            end
        end else begin
            m_held = 0;
        end

        if (stop) begin
            m_duty = 0;
        end else if (wrap) begin
`ifdef SOFT_START_EN
            if (tgt > m_duty)      m_duty = m_duty + 1;
            else if (tgt < m_duty) m_duty = m_duty - 1;
`else
            m_duty = tgt;
`endif
        end

        if (stop) begin
            m_state = 0;
        end else if (m_state == 0 && start) begin
            m_state  = 1;
            m_origin = nxt_ticks;
            m_entry  = nxt_ticks;
        end else if ((m_state == 1 || m_state == 2) && (m_ticks - m_entry >= STG)) begin
            m_state = m_state + 1;
            m_entry = nxt_ticks;
        end

        m_ticks = nxt_ticks;
        m_cyc++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        n_cyc++;
        check_eq("state", state, m_state);
        check_eq("duty", duty, m_duty);
        check_eq("pwm_out", pwm_out, m_pwm);
        check_eq("pwm_light", pwm_light, m_pwm);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_state(input int s, input int budget);
        int b;
        b = budget;
        while (m_state != s && b > 0) begin
            cyc();
            b--;
        end
        check_eq("wait_state", state, s);
    endtask

    initial begin
        int b, prev, k;
        int seen[4];
        rst = 1'b1; start = 1'b0; stop = 1'b0; inc = 1'b0; dec = 1'b0;
        run(3);
        rst = 1'b0;

        // Idle with button noise: nothing may move.
        for (int i = 0; i < 200; i++) begin
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            cyc();
        end
        inc = 1'b0; dec = 1'b0;
        check_eq("idle_state", state, 0);
        check_eq("idle_duty", duty, 0);

        // Full stage sequence into MANUAL.
        start = 1'b1; cyc(); start = 1'b0;
        check_eq("stage1_entry", state, 1);
        wait_state(2, 400);
        wait_state(3, 400);
        run(SETTLE);
        check_eq("manual_entry_duty", duty, 0);

        // Manual stepping, saturation at PERIOD, floor at 0, both-held no-op.
        inc = 1'b1; run(9 * TDIV); inc = 1'b0;
        run(SETTLE);
        check_eq("inc9_duty", duty, 3);
        inc = 1'b1; run(60 * TDIV); inc = 1'b0;
        run(SETTLE);
        check_eq("sat_duty", duty, PER);
        for (int i = 0; i < PER * TDIV; i++) begin
            cyc();
            check_eq("sat_pwm_high", pwm_out, 1);
        end
        dec = 1'b1; run(40 * TDIV); dec = 1'b0;
        run(SETTLE);
        check_eq("dec_floor_duty", duty, 0);
        inc = 1'b1; run(15 * TDIV); inc = 1'b0;
        run(SETTLE);
        check_eq("inc15_duty", duty, 5);
        inc = 1'b1; dec = 1'b1; run(30 * TDIV); inc = 1'b0; dec = 1'b0;
        run(SETTLE);
        check_eq("both_held_duty", duty, 5);

        // Stop from MANUAL, then stop mid-STAGE1 at pcnt=5.
        stop = 1'b1; cyc(); stop = 1'b0;
        check_eq("stop_manual_state", state, 0);
        start = 1'b1; cyc(); start = 1'b0;
        b = 200;
        while (!(m_state == 1 && (m_ticks - m_origin) >= PER
                 && ((m_ticks - m_origin) % PER) == 5) && b > 0) begin
            cyc();
            b--;
        end
        check_eq("stop_point_state", state, 1);
        stop = 1'b1; cyc(); stop = 1'b0;
        check_eq("stop_s1_state", state, 0);
        check_eq("stop_s1_duty", duty, 0);
        check_eq("stop_s1_pwm", pwm_out, 0);
        start = 1'b1; stop = 1'b1; run(20);
        check_eq("start_stop_idle", state, 0);
        stop = 1'b0; cyc(); start = 1'b0;
        check_eq("restart_after_stop", state, 1);

        // Manual duty survives a stop; reset clears everything.
        wait_state(3, 400);
        run(SETTLE);
        check_eq("manual_retained", duty, 5);
        inc = 1'b1; run(6 * TDIV); inc = 1'b0;
        run(SETTLE);
        check_eq("manual_duty7", duty, 7);
        rst = 1'b1; cyc(); rst = 1'b0;
        check_eq("rst_state", state, 0);
        check_eq("rst_duty", duty, 0);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_light", pwm_light, 0);

`ifdef SOFT_START_EN
        // Ramp from STAGE2 duty into a manual duty of 6, one step per wrap.
        start = 1'b1; cyc(); start = 1'b0;
        wait_state(3, 400);
        inc = 1'b1; run(18 * TDIV); inc = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        wait_state(3, 400);
        check_eq("soft_entry_duty", duty, S2);
        prev = duty;
        k = 0;
        b = 10 * PER * TDIV;
        while (k < 4 && b > 0) begin
            cyc();
            if (duty != prev) begin
                seen[k] = duty;
                prev = duty;
                k++;
            end
            b--;
        end
        for (int i = 0; i < 4; i++) check_eq("soft_ramp", seen[i], 3 + i);
`endif

        // Random traffic, including occasional stop and reset.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) inc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) dec = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) start = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 499) == 0);
            rst  = ($urandom_range(0, 2999) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
